// File: rtl/dram_cmd_seq.sv
// dram_cmd_seq: queued DRAM command sequencer with per-bank open-row tracking.
//
// Requests from the L2 side are buffered in a small FIFO. Each request at the
// head of the queue is decoded against the open-row table and turned into the
// PRE/ACT/RD/WR sequence it needs. Each command goes out over a 4-phase
// cmd_req/cmd_ack handshake. PAGE_POLICY selects open-page (rows stay open)
// or closed-page (every access is followed by a PRE to the same bank).
//
// Ports:
//   clk, rst_b                 clock, asynchronous active-low reset
//   req_valid/req_ready        request push handshake into the queue
//   req_rw/bank/row/col/wdata  request payload (rw: 1 = write, 0 = read)
//   cmd_req/cmd_ack            4-phase command handshake to the DRAM model
//   cmd                        00 ACT, 01 RD, 10 WR, 11 PRE
//   bank_id/row_id/col_id      command address (col_id is 0 outside RD/WR)
//   dram_wdata/dram_rdata      write data for WR / read data while cmd_ack=1
//   rsp_valid/rsp_data         one-cycle read response, data held until next read
//   hit_cnt/miss_cnt           saturating row-hit / row-miss statistics
module dram_cmd_seq #(
  parameter int NUM_OF_BANKS = 8,
  parameter int ROW_BITS     = 7,
  parameter int COL_BITS     = 3,
  parameter int DATA_WIDTH   = 8,
  parameter int FIFO_DEPTH   = 4,
  parameter int PAGE_POLICY  = 0,
  parameter int CNT_W        = 16,
  localparam int BANK_W      = $clog2(NUM_OF_BANKS)
) (
  input  logic                  clk,
  input  logic                  rst_b,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_rw,
  input  logic [BANK_W-1:0]     req_bank,
  input  logic [ROW_BITS-1:0]   req_row,
  input  logic [COL_BITS-1:0]   req_col,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  cmd_req,
  output logic [1:0]            cmd,
  input  logic                  cmd_ack,
  output logic [BANK_W-1:0]     bank_id,
  output logic [ROW_BITS-1:0]   row_id,
  output logic [COL_BITS-1:0]   col_id,
  output logic [DATA_WIDTH-1:0] dram_wdata,
  input  logic [DATA_WIDTH-1:0] dram_rdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic [CNT_W-1:0]      hit_cnt,
  output logic [CNT_W-1:0]      miss_cnt
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_DECODE, S_PRE, S_ACT, S_ACCESS, S_CLOSE} state_e;
  typedef enum logic [1:0] {C_ACT = 2'b00, C_RD = 2'b01, C_WR = 2'b10, C_PRE = 2'b11} cmd_code_e;

  typedef struct packed {
    logic                  rw;
    logic [BANK_W-1:0]     bank;
    logic [ROW_BITS-1:0]   row;
    logic [COL_BITS-1:0]   col;
    logic [DATA_WIDTH-1:0] wdata;
  } entry_t;

  typedef struct packed {
    logic [1:0]            code;
    logic [BANK_W-1:0]     bank;
    logic [ROW_BITS-1:0]   row;
    logic [COL_BITS-1:0]   col;
    logic [DATA_WIDTH-1:0] wdata;
  } cmd_fields_t;

  function automatic cmd_fields_t mk_cmd(input cmd_code_e code, input logic [BANK_W-1:0] b,
                                         input logic [ROW_BITS-1:0] r, input logic [COL_BITS-1:0] c,
                                         input logic [DATA_WIDTH-1:0] wd);
    mk_cmd = '{code: code, bank: b, row: r, col: c, wdata: wd};
  endfunction

  // Request queue
  entry_t              fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [PTR_W:0]      count;
  logic                push, pop;
  entry_t              head;

  // Open-row table
  logic [NUM_OF_BANKS-1:0] open_vld;
  logic [ROW_BITS-1:0]     open_row [NUM_OF_BANKS];

  // Sequencer state
  state_e              state_q, state_d;
  logic                phase_q, phase_d;
  logic                cmd_req_q, cmd_req_d;
  cmd_fields_t         cmd_q, cmd_d;
  logic                rsp_valid_q;
  logic [DATA_WIDTH-1:0] rsp_data_q;
  logic [CNT_W-1:0]    hit_q, miss_q;
  logic                capture, hit_inc, miss_inc, set_open, clr_open;
  cmd_fields_t         access_cmd;

  // req_ready looks only at the registered count, so a full queue refuses a
  // push even when the head is popped in the same cycle.
  assign req_ready = (count != FULL_CNT);
  assign push      = req_valid & req_ready;
  assign head      = fifo_mem[rd_ptr];
  assign access_cmd = mk_cmd(head.rw ? C_WR : C_RD, head.bank, head.row, head.col,
                             head.rw ? head.wdata : '0);

  // NOTE: every signal written here gets a default first so no path leaves one
  // unassigned; an unassigned path in combinational logic infers a latch.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    cmd_req_d = cmd_req_q;
    cmd_d     = cmd_q;
    capture   = 1'b0;
    pop       = 1'b0;
    hit_inc   = 1'b0;
    miss_inc  = 1'b0;
    set_open  = 1'b0;
    clr_open  = 1'b0;
    case (state_q)
      S_IDLE: if (count != '0) state_d = S_DECODE;
      S_DECODE: begin
        // Hold off while the previous command's ack is still high so a new
        // cmd_req never rises against an asserted cmd_ack.
        if (!cmd_ack) begin
          cmd_req_d = 1'b1;
          if (open_vld[head.bank] && open_row[head.bank] == head.row) begin
            hit_inc = 1'b1;
            state_d = S_ACCESS;
            cmd_d   = access_cmd;
          end else if (open_vld[head.bank]) begin
            miss_inc = 1'b1;
            state_d  = S_PRE;
            cmd_d    = mk_cmd(C_PRE, head.bank, open_row[head.bank], '0, '0);
          end else begin
            miss_inc = 1'b1;
            state_d  = S_ACT;
            cmd_d    = mk_cmd(C_ACT, head.bank, head.row, '0, '0);
          end
        end
      end
      default: begin
        // Command states: phase 0 waits for ack, phase 1 waits for its release.
        if (!phase_q) begin
          if (cmd_ack) begin
            cmd_req_d = 1'b0;
            phase_d   = 1'b1;
            capture   = (state_q == S_ACCESS) && !head.rw;
          end
        end else if (!cmd_ack) begin
          phase_d = 1'b0;
          case (state_q)
            S_PRE: begin
              clr_open  = 1'b1;
              state_d   = S_ACT;
              cmd_req_d = 1'b1;
              cmd_d     = mk_cmd(C_ACT, head.bank, head.row, '0, '0);
            end
            S_ACT: begin
              set_open  = 1'b1;
              state_d   = S_ACCESS;
              cmd_req_d = 1'b1;
              cmd_d     = access_cmd;
            end
            S_ACCESS: begin
              pop = 1'b1;
              if (PAGE_POLICY != 0) begin
                state_d   = S_CLOSE;
                cmd_req_d = 1'b1;
                cmd_d     = mk_cmd(C_PRE, head.bank, head.row, '0, '0);
              end else begin
                state_d = S_IDLE;
              end
            end
            default: begin // S_CLOSE
              clr_open = 1'b1;
              state_d  = S_IDLE;
            end
          endcase
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q     <= S_IDLE;
      phase_q     <= 1'b0;
      cmd_req_q   <= 1'b0;
      cmd_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      hit_q       <= '0;
      miss_q      <= '0;
      open_vld    <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      cmd_req_q   <= cmd_req_d;
      cmd_q       <= cmd_d;
      rsp_valid_q <= capture;
      if (capture) rsp_data_q <= dram_rdata;
      if (hit_inc && hit_q != '1)   hit_q  <= hit_q + CNT_W'(1);
      if (miss_inc && miss_q != '1) miss_q <= miss_q + CNT_W'(1);
      // PRE/CLOSE/ACT act on the bank of the command just completed.
      if (clr_open) open_vld[cmd_q.bank] <= 1'b0;
      if (set_open) open_vld[cmd_q.bank] <= 1'b1;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + (PTR_W+1)'(1);
      else if (pop && !push) count <= count - (PTR_W+1)'(1);
    end
  end

  // NOTE: storage arrays carry no reset; validity comes from the reset-cleared
  // count and open_vld bits, so stale contents are never used.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= '{rw: req_rw, bank: req_bank, row: req_row,
                                   col: req_col, wdata: req_wdata};
    if (set_open) open_row[cmd_q.bank] <= cmd_q.row;
  end

  assign cmd_req    = cmd_req_q;
  assign cmd        = cmd_q.code;
  assign bank_id    = cmd_q.bank;
  assign row_id     = cmd_q.row;
  assign col_id     = cmd_q.col;
  assign dram_wdata = cmd_q.wdata;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign hit_cnt    = hit_q;
  assign miss_cnt   = miss_q;

endmodule

// File: tb/tb_dram_cmd_seq.sv
// Testbench for dram_cmd_seq: one open-page and one closed-page instance, each
// with a DRAM responder that acks 8 ns after each cmd_req edge and logs every
// command it accepts as {cmd, bank, row, col, wdata}.
module tb_dram_cmd_seq;

  logic clk = 1'b0;
  logic rst_b = 1'b0;
  always #5 clk = ~clk;

  // Open-page instance signals
  logic       req_valid_o = 0, req_ready_o, req_rw_o = 0;
  logic [2:0] req_bank_o = 0, req_col_o = 0;
  logic [6:0] req_row_o = 0;
  logic [7:0] req_wdata_o = 0;
  logic       cmd_req_o, cmd_ack_o = 0, rsp_valid_o;
  logic [1:0] cmd_o;
  logic [2:0] bank_id_o, col_id_o;
  logic [6:0] row_id_o;
  logic [7:0] dram_wdata_o, dram_rdata_o = 0, rsp_data_o;
  logic [15:0] hit_o, miss_o;

  // Closed-page instance signals
  logic       req_valid_c = 0, req_ready_c, req_rw_c = 0;
  logic [2:0] req_bank_c = 0, req_col_c = 0;
  logic [6:0] req_row_c = 0;
  logic [7:0] req_wdata_c = 0;
  logic       cmd_req_c, cmd_ack_c = 0, rsp_valid_c;
  logic [1:0] cmd_c;
  logic [2:0] bank_id_c, col_id_c;
  logic [6:0] row_id_c;
  logic [7:0] dram_wdata_c, dram_rdata_c = 0, rsp_data_c;
  logic [15:0] hit_c, miss_c;

  dram_cmd_seq #(.PAGE_POLICY(0)) u_open (
    .clk(clk), .rst_b(rst_b), .req_valid(req_valid_o), .req_ready(req_ready_o),
    .req_rw(req_rw_o), .req_bank(req_bank_o), .req_row(req_row_o), .req_col(req_col_o),
    .req_wdata(req_wdata_o), .cmd_req(cmd_req_o), .cmd(cmd_o), .cmd_ack(cmd_ack_o),
    .bank_id(bank_id_o), .row_id(row_id_o), .col_id(col_id_o), .dram_wdata(dram_wdata_o),
    .dram_rdata(dram_rdata_o), .rsp_valid(rsp_valid_o), .rsp_data(rsp_data_o),
    .hit_cnt(hit_o), .miss_cnt(miss_o));

  dram_cmd_seq #(.PAGE_POLICY(1)) u_closed (
    .clk(clk), .rst_b(rst_b), .req_valid(req_valid_c), .req_ready(req_ready_c),
    .req_rw(req_rw_c), .req_bank(req_bank_c), .req_row(req_row_c), .req_col(req_col_c),
    .req_wdata(req_wdata_c), .cmd_req(cmd_req_c), .cmd(cmd_c), .cmd_ack(cmd_ack_c),
    .bank_id(bank_id_c), .row_id(row_id_c), .col_id(col_id_c), .dram_wdata(dram_wdata_c),
    .dram_rdata(dram_rdata_c), .rsp_valid(rsp_valid_c), .rsp_data(rsp_data_c),
    .hit_cnt(hit_c), .miss_cnt(miss_c));

  int checks = 0;
  int errors = 0;
  logic [22:0] log_o[$];
  logic [22:0] log_c[$];
  logic hold_o = 1'b0;
  int rsp_n_o = 0, rsp_n_c = 0;

  localparam logic [1:0] ACT = 2'b00, RD = 2'b01, WR = 2'b10, PRE = 2'b11;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ent(input logic [1:0] c, input logic [2:0] b,
                                      input logic [6:0] r, input logic [2:0] col,
                                      input logic [7:0] wd);
    return 32'({c, b, r, col, wd});
  endfunction

  // DRAM responders
  always begin
    @(posedge cmd_req_o);
    #8;
    wait (!hold_o);
    if (cmd_req_o) begin
      log_o.push_back({cmd_o, bank_id_o, row_id_o, col_id_o, dram_wdata_o});
      cmd_ack_o = 1'b1;
      wait (!cmd_req_o);
      #8;
      cmd_ack_o = 1'b0;
    end
  end

  always begin
    @(posedge cmd_req_c);
    #8;
    if (cmd_req_c) begin
      log_c.push_back({cmd_c, bank_id_c, row_id_c, col_id_c, dram_wdata_c});
      cmd_ack_c = 1'b1;
      wait (!cmd_req_c);
      #8;
      cmd_ack_c = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rsp_valid_o) rsp_n_o++;
    if (rsp_valid_c) rsp_n_c++;
  end

  // Drive one request for one cycle; rdy is req_ready seen while valid is up.
  task automatic push(input bit sel, input logic rw, input logic [2:0] b, input logic [6:0] r,
                      input logic [2:0] c, input logic [7:0] wd, output logic rdy);
    @(negedge clk);
    if (!sel) begin
      req_rw_o = rw; req_bank_o = b; req_row_o = r; req_col_o = c; req_wdata_o = wd;
      req_valid_o = 1'b1; rdy = req_ready_o;
    end else begin
      req_rw_c = rw; req_bank_c = b; req_row_c = r; req_col_c = c; req_wdata_c = wd;
      req_valid_c = 1'b1; rdy = req_ready_c;
    end
    @(posedge clk);
    #1;
    req_valid_o = 1'b0;
    req_valid_c = 1'b0;
  endtask

  // Wait (bounded) for n logged commands, then let the sequencer settle.
  task automatic wait_log(input bit sel, input int n, input string tag);
    for (int i = 0; i < 300; i++) begin
      if ((sel ? log_c.size() : log_o.size()) >= n) break;
      @(negedge clk);
    end
    repeat (8) @(negedge clk);
    check({tag, "_ncmd"}, 32'(sel ? log_c.size() : log_o.size()), 32'(n));
  endtask

  logic rdy;
  int   lat;

  initial begin
    // Reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_req", 32'(cmd_req_o), 0);
    check("rst_rsp_valid", 32'(rsp_valid_o), 0);
    check("rst_hit", 32'(hit_o), 0);
    check("rst_miss", 32'(miss_o), 0);
    check("rst_ready", 32'(req_ready_o), 1);
    rst_b = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 32'(req_ready_o), 1);

    // Write to a closed bank: ACT then WR
    push(0, 1, 3'd3, 7'd5, 3'd2, 8'h3C, rdy);
    wait_log(0, 2, "wr");
    if (log_o.size() >= 2) begin
      check("wr_act", 32'(log_o[0]), ent(ACT, 3, 5, 0, 0));
      check("wr_wr", 32'(log_o[1]), ent(WR, 3, 5, 2, 8'h3C));
    end
    check("wr_miss", 32'(miss_o), 1);
    check("wr_hit", 32'(hit_o), 0);
    check("wr_no_rsp", 32'(rsp_n_o), 0);

    // Row hit read, with minimum latency
    log_o.delete();
    dram_rdata_o = 8'hA5;
    push(0, 0, 3'd3, 7'd5, 3'd4, 8'h00, rdy);
    lat = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (cmd_req_o) begin lat = k; break; end
    end
    check("hit_latency", 32'(lat), 2);
    wait_log(0, 1, "hit");
    if (log_o.size() >= 1) check("hit_rd", 32'(log_o[0]), ent(RD, 3, 5, 4, 0));
    check("hit_hit", 32'(hit_o), 1);
    check("hit_rsp_n", 32'(rsp_n_o), 1);
    check("hit_rsp_data", 32'(rsp_data_o), 32'hA5);

    // Row conflict: PRE old row, ACT new row, RD
    log_o.delete();
    dram_rdata_o = 8'h5A;
    push(0, 0, 3'd3, 7'd9, 3'd0, 8'h00, rdy);
    wait_log(0, 3, "conf");
    if (log_o.size() >= 3) begin
      check("conf_pre", 32'(log_o[0]), ent(PRE, 3, 5, 0, 0));
      check("conf_act", 32'(log_o[1]), ent(ACT, 3, 9, 0, 0));
      check("conf_rd", 32'(log_o[2]), ent(RD, 3, 9, 0, 0));
    end
    check("conf_miss", 32'(miss_o), 2);
    check("conf_rsp_data", 32'(rsp_data_o), 32'h5A);

    // Other bank, closed: ACT only, no PRE
    log_o.delete();
    dram_rdata_o = 8'h77;
    push(0, 0, 3'd6, 7'd9, 3'd7, 8'h00, rdy);
    wait_log(0, 2, "b6");
    if (log_o.size() >= 2) begin
      check("b6_act", 32'(log_o[0]), ent(ACT, 6, 9, 0, 0));
      check("b6_rd", 32'(log_o[1]), ent(RD, 6, 9, 7, 0));
    end
    check("b6_miss", 32'(miss_o), 3);

    // Queue full while ack is held off
    log_o.delete();
    hold_o = 1'b1;
    dram_rdata_o = 8'hC3;
    for (int i = 0; i < 5; i++) begin
      push(0, 0, 3'd6, 7'd9, 3'(i + 1), 8'h00, rdy);
      check($sformatf("full_ready%0d", i), 32'(rdy), (i < 4) ? 1 : 0);
    end
    @(negedge clk);
    check("full_ready_held", 32'(req_ready_o), 0);
    hold_o = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (req_ready_o) break;
      @(negedge clk);
    end
    check("full_ready_back", 32'(req_ready_o), 1);
    check("full_ready_after_first", 32'(log_o.size()), 1);
    wait_log(0, 4, "drain");
    for (int i = 0; i < 4; i++)
      if (log_o.size() > i) check($sformatf("drain_rd%0d", i), 32'(log_o[i]), ent(RD, 6, 9, 3'(i + 1), 0));
    check("drain_hit", 32'(hit_o), 5);
    check("drain_miss", 32'(miss_o), 3);
    check("drain_rsp_n", 32'(rsp_n_o), 7);

    // Closed-page: two reads of b2 r7, then a third
    dram_rdata_c = 8'h4D;
    push(1, 0, 3'd2, 7'd7, 3'd1, 8'h00, rdy);
    push(1, 0, 3'd2, 7'd7, 3'd1, 8'h00, rdy);
    wait_log(1, 6, "cp");
    for (int j = 0; j < 2; j++)
      if (log_c.size() >= 6) begin
        check($sformatf("cp_act%0d", j), 32'(log_c[3*j]),   ent(ACT, 2, 7, 0, 0));
        check($sformatf("cp_rd%0d", j),  32'(log_c[3*j+1]), ent(RD, 2, 7, 1, 0));
        check($sformatf("cp_pre%0d", j), 32'(log_c[3*j+2]), ent(PRE, 2, 7, 0, 0));
      end
    check("cp_hit", 32'(hit_c), 0);
    check("cp_miss", 32'(miss_c), 2);
    log_c.delete();
    push(1, 0, 3'd2, 7'd7, 3'd3, 8'h00, rdy);
    wait_log(1, 3, "cp3");
    if (log_c.size() >= 1) check("cp3_act_first", 32'(log_c[0]), ent(ACT, 2, 7, 0, 0));
    check("cp3_miss", 32'(miss_c), 3);
    check("cp_rsp_n", 32'(rsp_n_c), 3);
    check("cp_rsp_data", 32'(rsp_data_c), 32'h4D);

    // Asynchronous reset while cmd_req is high
    hold_o = 1'b1;
    push(0, 0, 3'd6, 7'd9, 3'd0, 8'h00, rdy);
    for (int i = 0; i < 20; i++) begin
      if (cmd_req_o) break;
      @(negedge clk);
    end
    check("arst_req_up", 32'(cmd_req_o), 1);
    @(posedge clk);
    #3;
    rst_b = 1'b0;
    #1;
    check("arst_cmd_req", 32'(cmd_req_o), 0);
    check("arst_hit", 32'(hit_o), 0);
    check("arst_ready", 32'(req_ready_o), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
